// File: rtl/mt_fake_axi_mem_pkg.sv
// Shared types for the latency-programmable fake AXI4 memory: burst/resp codes,
// captured burst control fields, and the write-path state encoding.
package mt_fake_axi_mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Width-independent part of a burst request; id/addr/countdown live beside it
    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
    } rd_req_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_WAIT = 2'b10,
        W_RESP = 2'b11
    } wr_state_e;

endpackage

// File: rtl/mt_fake_axi_burst_addr.sv
// Purpose: next beat address for an AXI4 burst (FIXED/INCR/WRAP, reserved as INCR).
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module mt_fake_axi_burst_addr
    import mt_fake_axi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 64
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    always_comb begin
        step      = ADDR_WIDTH'(1) << size;
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
            default:     next_addr = addr + step;
        endcase
    end

endmodule

// File: rtl/mt_fake_axi_mem_lat.sv
// Purpose: AXI4 slave fake memory with programmable read/write latency; optional FAKE_AXI_MEM_RANGE_CHECK_EN.
// Latency: first R beat RD_LATENCY cycles after AR, bvalid WR_LATENCY cycles after last W.
// Backpressure: arready drops when MAX_RD_OUTST reads are queued; one write in flight; R/B hold until ready.
module mt_fake_axi_mem_lat
    import mt_fake_axi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 512,
    parameter int ID_WIDTH       = 6,
    parameter int MEM_WORDS_LOG2 = 16,
    parameter int RD_LATENCY     = 8,
    parameter int WR_LATENCY     = 4,
    parameter int MAX_RD_OUTST   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic                    err_wlast
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam int MEM_WORDS  = 2 ** MEM_WORDS_LOG2;
    localparam int PTR_W      = $clog2(MAX_RD_OUTST);
    localparam int CNT_W      = $clog2(RD_LATENCY + 1);
    localparam int WCNT_W     = $clog2(WR_LATENCY + 1);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // ---------------- read path ----------------
    logic [ID_WIDTH-1:0]   q_id   [MAX_RD_OUTST];
    logic [ADDR_WIDTH-1:0] q_addr [MAX_RD_OUTST];
    rd_req_t               q_req  [MAX_RD_OUTST];
    logic [CNT_W-1:0]      q_cnt  [MAX_RD_OUTST];
    logic [PTR_W-1:0]      q_wr_ptr, q_rd_ptr, head_nxt, start_idx;
    logic [PTR_W:0]        q_count;
    logic [ADDR_WIDTH-1:0] r_addr, r_next;
    logic [7:0]            r_beat;
    logic                  ar_hs, r_hs, r_last_hs, r_start, r_oor;
    rd_req_t               head;

    assign head          = q_req[q_rd_ptr];
    assign head_nxt      = q_rd_ptr + PTR_W'(1);
    assign s_axi_arready = (q_count != (PTR_W+1)'(MAX_RD_OUTST));
    assign ar_hs         = s_axi_arvalid && s_axi_arready;
    assign r_hs          = s_axi_rvalid && s_axi_rready;
    assign r_last_hs     = r_hs && s_axi_rlast;

    // A finishing burst hands R straight to the next ready entry without a bubble
    always_comb begin
        r_start   = 1'b0;
        start_idx = q_rd_ptr;
        if (!s_axi_rvalid) begin
            r_start = (q_count != '0) && (q_cnt[q_rd_ptr] == '0);
        end else if (r_last_hs) begin
            start_idx = head_nxt;
            r_start   = (q_count > (PTR_W+1)'(1)) && (q_cnt[head_nxt] == '0);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_RD_OUTST; i++) begin
            if (q_cnt[i] != '0) q_cnt[i] <= q_cnt[i] - CNT_W'(1);
        end
        if (ar_hs) begin
            q_id[q_wr_ptr]   <= s_axi_arid;
            q_addr[q_wr_ptr] <= s_axi_araddr;
            q_req[q_wr_ptr]  <= '{len: s_axi_arlen, size: s_axi_arsize, burst: s_axi_arburst};
            q_cnt[q_wr_ptr]  <= CNT_W'(RD_LATENCY - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_wr_ptr     <= '0;
            q_rd_ptr     <= '0;
            q_count      <= '0;
            s_axi_rvalid <= 1'b0;
            r_addr       <= '0;
            r_beat       <= '0;
        end else begin
            if (ar_hs)     q_wr_ptr <= q_wr_ptr + PTR_W'(1);
            if (r_last_hs) q_rd_ptr <= head_nxt;
            if (ar_hs && !r_last_hs)      q_count <= q_count + (PTR_W+1)'(1);
            else if (!ar_hs && r_last_hs) q_count <= q_count - (PTR_W+1)'(1);
            if (r_start) begin
                s_axi_rvalid <= 1'b1;
                r_addr       <= q_addr[start_idx];
                r_beat       <= '0;
            end else if (r_last_hs) begin
                s_axi_rvalid <= 1'b0;
            end else if (r_hs) begin
                r_addr <= r_next;
                r_beat <= r_beat + 8'd1;
            end
        end
    end

    mt_fake_axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_addr (
        .addr      (r_addr),
        .len       (head.len),
        .size      (head.size),
        .burst     (head.burst),
        .next_addr (r_next)
    );

    // ---------------- write path ----------------
    wr_state_e             w_state;
    rd_req_t               w_req;
    logic [ADDR_WIDTH-1:0] w_addr, w_next;
    logic [7:0]            w_beat;
    logic [WCNT_W-1:0]     w_cnt;
    logic                  w_dec, w_oor, w_hs, w_last;

    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign w_last = (w_beat == w_req.len);

`ifdef FAKE_AXI_MEM_RANGE_CHECK_EN
    assign r_oor = |r_addr[ADDR_WIDTH-1:ADDR_LSB+MEM_WORDS_LOG2];
    assign w_oor = |w_addr[ADDR_WIDTH-1:ADDR_LSB+MEM_WORDS_LOG2];
`else
    assign r_oor = 1'b0;
    assign w_oor = 1'b0;
`endif

    assign s_axi_rid   = q_id[q_rd_ptr];
    assign s_axi_rlast = s_axi_rvalid && (r_beat == head.len);
    assign s_axi_rresp = (s_axi_rvalid && r_oor) ? RESP_DECERR : RESP_OKAY;
    // Combinational read ahead of the clocked write gives read-before-write on collisions
    assign s_axi_rdata = (s_axi_rvalid && !r_oor) ? mem[r_addr[ADDR_LSB +: MEM_WORDS_LOG2]] : '0;

    always_ff @(posedge clk) begin
        if (w_hs && !w_oor) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (s_axi_wstrb[b])
                    mem[w_addr[ADDR_LSB +: MEM_WORDS_LOG2]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_bid     <= '0;
            w_addr        <= '0;
            w_req         <= '0;
            w_beat        <= '0;
            w_cnt         <= '0;
            w_dec         <= 1'b0;
            err_wlast     <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (s_axi_awvalid) begin
                    s_axi_awready <= 1'b0;
                    s_axi_wready  <= 1'b1;
                    s_axi_bid     <= s_axi_awid;
                    w_addr        <= s_axi_awaddr;
                    w_req         <= '{len: s_axi_awlen, size: s_axi_awsize, burst: s_axi_awburst};
                    w_beat        <= '0;
                    w_dec         <= 1'b0;
                    w_state       <= W_DATA;
                end
                W_DATA: if (s_axi_wvalid) begin
                    w_dec <= w_dec | w_oor;
                    if (s_axi_wlast != w_last) err_wlast <= 1'b1;
                    // awlen, not wlast, decides where the burst ends
                    if (w_last) begin
                        s_axi_wready <= 1'b0;
                        w_cnt        <= WCNT_W'(WR_LATENCY - 1);
                        w_state      <= W_WAIT;
                    end else begin
                        w_addr <= w_next;
                        w_beat <= w_beat + 8'd1;
                    end
                end
                W_WAIT: if (w_cnt == '0) begin
                    s_axi_bvalid <= 1'b1;
                    s_axi_bresp  <= w_dec ? RESP_DECERR : RESP_OKAY;
                    w_state      <= W_RESP;
                end else begin
                    w_cnt <= w_cnt - WCNT_W'(1);
                end
                W_RESP: if (s_axi_bready) begin
                    s_axi_bvalid  <= 1'b0;
                    s_axi_awready <= 1'b1;
                    w_state       <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    mt_fake_axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_addr (
        .addr      (w_addr),
        .len       (w_req.len),
        .size      (w_req.size),
        .burst     (w_req.burst),
        .next_addr (w_next)
    );

endmodule
